// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port integer register file with a hardwired zero
// register, a per-register busy scoreboard for hazard detection, and a
// sequential post-reset clear sweep (one entry per cycle).
// Optional feature macro: REG_FILE_BYPASS_EN (write-to-read forwarding).
module reg_file_mp #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] o_rd_data,
  output logic [NUM_RD-1:0]            o_rd_busy,
  input  logic [NUM_WR-1:0]            i_wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] i_wr_data,
  input  logic                         i_claim_en,
  input  logic [ADDR_WIDTH-1:0]        i_claim_addr,
  output logic                         o_ready
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    ready_q, ready_d;
  logic [NUM_REGS-1:0]     busy_q, busy_d;
  // Entry 0 is the hardwired zero register, so it has no storage.
  logic [DATA_WIDTH-1:0]   mem_q [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0]   mem_d [1:NUM_REGS-1];

  logic [ADDR_WIDTH-1:0]   rd_addr [NUM_RD];
  logic [ADDR_WIDTH-1:0]   wr_addr [NUM_WR];
  logic [DATA_WIDTH-1:0]   wr_data [NUM_WR];

  // Unpack the flat port buses into per-port views.
  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd_unpack
    assign rd_addr[r] = i_rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
  end
  for (genvar w = 0; w < NUM_WR; w++) begin : g_wr_unpack
    assign wr_addr[w] = i_wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH];
    assign wr_data[w] = i_wr_data[w*DATA_WIDTH +: DATA_WIDTH];
  end

  // A register index with real storage: non-zero and inside the array.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (a != '0) && (32'(a) < NUM_REGS);
  endfunction

  // Next-state: clear sweep in INIT; writes then claims in RUN.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    mem_d   = mem_q;
    if (state_q == ST_INIT) begin
      mem_d[cnt_q] = '0;
      if (cnt_q == LAST_IDX) begin
        state_d = ST_RUN;
        ready_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      // Ascending port order lets the higher index win a same-address collision.
      for (int w = 0; w < NUM_WR; w++) begin
        if (i_wr_en[w] && addr_ok(wr_addr[w])) begin
          mem_d[wr_addr[w]]  = wr_data[w];
          busy_d[wr_addr[w]] = 1'b0;
        end
      end
      // A claim after the writes: the new producer keeps the register busy.
      if (i_claim_en && addr_ok(i_claim_addr)) begin
        busy_d[i_claim_addr] = 1'b1;
      end
    end
  end

  // Control state register with synchronous reset restarting the sweep.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (i_rst) begin
      state_q <= ST_INIT;
      cnt_q   <= ADDR_WIDTH'(1);
      busy_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  // Array storage update.
  always_ff @(posedge i_clk) begin
    // NOTE: the array is deliberately not reset; the INIT sweep clears it one entry per cycle.
    mem_q <= mem_d;
  end

  // Combinational read ports, zero-latency.
  always_comb begin
    o_rd_data = '0;
    o_rd_busy = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      if (state_q == ST_RUN && addr_ok(rd_addr[r])) begin
        o_rd_data[r*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_addr[r]];
        o_rd_busy[r]                          = busy_q[rd_addr[r]];
`ifdef REG_FILE_BYPASS_EN
        // Forward same-cycle write data; highest write port wins.
        for (int w = 0; w < NUM_WR; w++) begin
          if (i_wr_en[w] && wr_addr[w] == rd_addr[r]) begin
            o_rd_data[r*DATA_WIDTH +: DATA_WIDTH] = wr_data[w];
            o_rd_busy[r] = i_claim_en && (i_claim_addr == rd_addr[r]);
          end
        end
`endif
      end
    end
  end

  assign o_ready = ready_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp (default parameters). Expected read
// results are queued when read addresses are driven and popped when sampled.
module tb_reg_file_mp;

  localparam int DW = 64;
  localparam int AW = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [2*AW-1:0] rd_addr;
  logic [2*DW-1:0] rd_data;
  logic [1:0]      rd_busy;
  logic [1:0]      wr_en;
  logic [2*AW-1:0] wr_addr;
  logic [2*DW-1:0] wr_data;
  logic            claim_en;
  logic [AW-1:0]   claim_addr;
  logic            ready;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    int          port;
    logic [63:0] data;
    logic        busy;
    string       tag;
  } exp_t;

  exp_t sb[$];

  reg_file_mp dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rd_addr   (rd_addr),
    .o_rd_data   (rd_data),
    .o_rd_busy   (rd_busy),
    .i_wr_en     (wr_en),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .i_claim_en  (claim_en),
    .i_claim_addr(claim_addr),
    .o_ready     (ready)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational read outputs settle before sampling.
  task automatic settle();
    #2;
  endtask

  task automatic idle();
    wr_en      = '0;
    claim_en   = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    claim_addr = '0;
  endtask

  task automatic drive_wr(input int w, input logic [AW-1:0] a, input logic [63:0] d);
    wr_en[w]             = 1'b1;
    wr_addr[w*AW +: AW]  = a;
    wr_data[w*DW +: DW]  = d;
  endtask

  // Drive a read address and queue its expected result.
  task automatic expect_rd(input int p, input logic [AW-1:0] a, input logic [63:0] d,
                           input logic b, input string tag);
    exp_t e;
    rd_addr[p*AW +: AW] = a;
    e.port = p; e.data = d; e.busy = b; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    idle();
    rd_addr = '0;
    repeat (3) tick();
    n_checks++;
    if (ready !== 1'b0) begin
      n_err++; $display("FAIL reset_ready: got %b want 0", ready);
    end
    rst = 1'b0;
    // Writes/claims during INIT must not leak to outputs.
    drive_wr(1, 5'd6, 64'h1234);
    claim_en = 1'b1; claim_addr = 5'd5;
    expect_rd(0, 5'd5, 64'h0, 1'b0, "init_rd0");
    expect_rd(1, 5'd6, 64'h0, 1'b0, "init_rd1");
    settle();
    while (sb.size() != 0) begin
      e = sb.pop_front(); n_checks++;
      if (rd_data[e.port*DW +: DW] !== e.data || rd_busy[e.port] !== e.busy) begin
        n_err++; $display("FAIL %s: data=%h busy=%b want data=%h busy=%b", e.tag,
                          rd_data[e.port*DW +: DW], rd_busy[e.port], e.data, e.busy);
      end
    end
    idle();
    for (int i = 0; i < 31; i++) begin
      n_checks++;
      if (ready !== 1'b0) begin
        n_err++; $display("FAIL init_ready_low[%0d]: got %b want 0", i, ready);
      end
      tick();
    end
    n_checks++;
    if (ready !== 1'b1) begin
      n_err++; $display("FAIL init_ready_high: got %b want 1", ready);
    end
  endtask

  // Every address reads 0 with busy 0.
  task automatic test_all_zero(input string tag);
    exp_t e;
    for (int a = 1; a < 32; a += 2) begin
      expect_rd(0, AW'(a), 64'h0, 1'b0, tag);
      expect_rd(1, (a + 1 < 32) ? AW'(a + 1) : AW'(0), 64'h0, 1'b0, tag);
      settle();
      while (sb.size() != 0) begin
        e = sb.pop_front(); n_checks++;
        if (rd_data[e.port*DW +: DW] !== e.data || rd_busy[e.port] !== e.busy) begin
          n_err++; $display("FAIL %s addr %0d: data=%h busy=%b want data=%h busy=%b", e.tag,
                            rd_addr[e.port*AW +: AW], rd_data[e.port*DW +: DW],
                            rd_busy[e.port], e.data, e.busy);
        end
      end
      tick();
    end
  endtask

  task automatic test_basic_rw();
    exp_t e;
    drive_wr(0, 5'd5, 64'hDEAD_BEEF_0000_0001);
    tick();
    idle();
    drive_wr(0, 5'd0, 64'hFF);
    expect_rd(0, 5'd5, 64'hDEAD_BEEF_0000_0001, 1'b0, "basic_rd5");
    expect_rd(1, 5'd0, 64'h0, 1'b0, "basic_rd0");
    settle();
    while (sb.size() != 0) begin
      e = sb.pop_front(); n_checks++;
      if (rd_data[e.port*DW +: DW] !== e.data || rd_busy[e.port] !== e.busy) begin
        n_err++; $display("FAIL %s: data=%h busy=%b want data=%h busy=%b", e.tag,
                          rd_data[e.port*DW +: DW], rd_busy[e.port], e.data, e.busy);
      end
    end
    tick();
    idle();
    expect_rd(0, 5'd0, 64'h0, 1'b0, "zero_reg_after_wr");
    settle();
    while (sb.size() != 0) begin
      e = sb.pop_front(); n_checks++;
      if (rd_data[e.port*DW +: DW] !== e.data || rd_busy[e.port] !== e.busy) begin
        n_err++; $display("FAIL %s: data=%h busy=%b want data=%h busy=%b", e.tag,
                          rd_data[e.port*DW +: DW], rd_busy[e.port], e.data, e.busy);
      end
    end
  endtask

  task automatic test_collision();
    exp_t e;
    drive_wr(0, 5'd7, 64'h11);
    drive_wr(1, 5'd7, 64'h22);
    tick();
    idle();
    expect_rd(0, 5'd7, 64'h22, 1'b0, "collision_rd0");
    expect_rd(1, 5'd5, 64'hDEAD_BEEF_0000_0001, 1'b0, "collision_rd1_other");
    settle();
    while (sb.size() != 0) begin
      e = sb.pop_front(); n_checks++;
      if (rd_data[e.port*DW +: DW] !== e.data || rd_busy[e.port] !== e.busy) begin
        n_err++; $display("FAIL %s: data=%h busy=%b want data=%h busy=%b", e.tag,
                          rd_data[e.port*DW +: DW], rd_busy[e.port], e.data, e.busy);
      end
    end
  endtask

  task automatic test_scoreboard();
    exp_t e;
    // Each row: claim, write, expected busy and data of addr 9 next cycle.
    logic        row_claim [3] = '{1'b1, 1'b0, 1'b1};
    logic        row_wr    [3] = '{1'b0, 1'b1, 1'b1};
    logic        row_busy  [3] = '{1'b1, 1'b0, 1'b1};
    logic [63:0] row_data  [3] = '{64'h0, 64'h5, 64'h5};
    for (int i = 0; i < 3; i++) begin
      tick();
      claim_en = row_claim[i]; claim_addr = 5'd9;
      if (row_wr[i]) drive_wr(0, 5'd9, 64'h5);
      tick();
      idle();
      expect_rd(1, 5'd9, row_data[i], row_busy[i], $sformatf("scoreboard_step%0d", i));
      expect_rd(0, 5'd7, 64'h22, 1'b0, $sformatf("scoreboard_other%0d", i));
      settle();
      while (sb.size() != 0) begin
        e = sb.pop_front(); n_checks++;
        if (rd_data[e.port*DW +: DW] !== e.data || rd_busy[e.port] !== e.busy) begin
          n_err++; $display("FAIL %s: data=%h busy=%b want data=%h busy=%b", e.tag,
                            rd_data[e.port*DW +: DW], rd_busy[e.port], e.data, e.busy);
        end
      end
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    tick();
    drive_wr(0, 5'd3, 64'hABCD);
`ifdef REG_FILE_BYPASS_EN
    expect_rd(0, 5'd3, 64'hABCD, 1'b0, "bypass_same_cycle");
`else
    expect_rd(0, 5'd3, 64'h0, 1'b0, "no_bypass_same_cycle");
`endif
    expect_rd(1, 5'd9, 64'h5, 1'b1, "bypass_other_port");
    settle();
    while (sb.size() != 0) begin
      e = sb.pop_front(); n_checks++;
      if (rd_data[e.port*DW +: DW] !== e.data || rd_busy[e.port] !== e.busy) begin
        n_err++; $display("FAIL %s: data=%h busy=%b want data=%h busy=%b", e.tag,
                          rd_data[e.port*DW +: DW], rd_busy[e.port], e.data, e.busy);
      end
    end
    tick();
    idle();
    expect_rd(0, 5'd3, 64'hABCD, 1'b0, "bypass_next_cycle");
    settle();
    while (sb.size() != 0) begin
      e = sb.pop_front(); n_checks++;
      if (rd_data[e.port*DW +: DW] !== e.data || rd_busy[e.port] !== e.busy) begin
        n_err++; $display("FAIL %s: data=%h busy=%b want data=%h busy=%b", e.tag,
                          rd_data[e.port*DW +: DW], rd_busy[e.port], e.data, e.busy);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    exp_t e;
    int   cycles;
    tick();
    drive_wr(0, 5'd4, 64'h77);
    tick();
    idle();
    claim_en = 1'b1; claim_addr = 5'd12;
    expect_rd(0, 5'd4, 64'h77, 1'b0, "pre_reset_rd4");
    settle();
    while (sb.size() != 0) begin
      e = sb.pop_front(); n_checks++;
      if (rd_data[e.port*DW +: DW] !== e.data || rd_busy[e.port] !== e.busy) begin
        n_err++; $display("FAIL %s: data=%h busy=%b want data=%h busy=%b", e.tag,
                          rd_data[e.port*DW +: DW], rd_busy[e.port], e.data, e.busy);
      end
    end
    tick();
    idle();
    // Reset in RUN, then again mid-sweep at count 10.
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (9) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    drive_wr(0, 5'd4, 64'h99);
    drive_wr(1, 5'd20, 64'h55);
    claim_en = 1'b1; claim_addr = 5'd12;
    cycles = 0;
    while (ready !== 1'b1 && cycles < 100) begin
      tick();
      cycles++;
    end
    idle();
    n_checks++;
    if (cycles != 31) begin
      n_err++; $display("FAIL restart_sweep_len: got %0d cycles want 31", cycles);
    end
    test_all_zero("post_restart_zero");
  endtask

  initial begin
    test_reset();
    test_all_zero("post_init_zero");
    test_basic_rw();
    test_collision();
    test_scoreboard();
    test_bypass();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
